// File: rtl/buffer_wr_arbiter.sv
// Round-robin arbiter for the write port of the 8-entry dual-clock buffer.
// Hands out bounded bursts to one requester at a time and stalls on buffer_full.
// After buffer_full it drains until buffer_empty, so the buffer write pointer can rewind.
module buffer_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk_1,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DW-1:0]        req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       buffer_full,
    input  logic                       buffer_empty,
    output logic [DW-1:0]              data_1,
    output logic                       data_1_en,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic [15:0]                word_count
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_burst_cnt;
    logic [15:0]     r_word_count;

    logic [IW-1:0]   w_winner;
    logic            w_found;
    logic [IW-1:0]   w_rr_next;
    logic            w_accept;
    logic            w_burst_last;
    logic [DW-1:0]   w_slices [N_REQ];

    // State register
    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Round-robin search that starts at r_rr_ptr and wraps modulo N_REQ
    always_comb begin
        int unsigned w_idx;
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = (32'(r_rr_ptr) + k) % N_REQ;
            if (!w_found && req[IW'(w_idx)]) begin
                w_winner = IW'(w_idx);
                w_found  = 1'b1;
            end
        end
        w_rr_next = (w_winner == IW'(N_REQ - 1)) ? '0 : w_winner + IW'(1);
    end

    // Next-state logic. buffer_full has priority over every other exit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (buffer_full) begin
                    w_state_next = S_DRAIN;
                end else if (|req) begin
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (buffer_full) begin
                    w_state_next = S_DRAIN;
                end else if (w_accept && w_burst_last) begin
                    w_state_next = S_IDLE;
                end else if (!req[r_owner]) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (buffer_empty) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs. Only the owner's req bit reaches data_1_en, so X on the
    // req_data of other requesters cannot reach the buffer enable.
    always_comb begin
        req_ready    = '0;
        grant_valid  = (r_state == S_BURST);
        w_accept     = (r_state == S_BURST) && req[r_owner] && !buffer_full;
        w_burst_last = (r_burst_cnt == CW'(MAX_BURST - 1));
        if ((r_state == S_BURST) && !buffer_full) begin
            req_ready[r_owner] = 1'b1;
        end
        data_1_en = w_accept;
    end

    // Split the packed request data into one word per requester for the data_1 mux
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_slices[i] = req_data[i*DW +: DW];
        end
    end

    assign data_1     = w_slices[r_owner];
    assign grant_id   = r_owner;
    assign word_count = r_word_count;

    // Owner, round-robin pointer and counters
    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_burst_cnt  <= '0;
            r_word_count <= '0;
        end else begin
            if ((r_state == S_IDLE) && !buffer_full && w_found) begin
                r_owner     <= w_winner;
                r_rr_ptr    <= w_rr_next;
                r_burst_cnt <= '0;
            end
            if (w_accept) begin
                r_burst_cnt  <= r_burst_cnt + CW'(1);
                r_word_count <= r_word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// Self-checking bench for buffer_wr_arbiter.
// It runs directed scenarios first, then randomized traffic.
// A flag-based reference model, advanced once per clock edge, predicts every output.
module tb_buffer_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int IW = 2;

    logic              clk_1 = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              buffer_full;
    logic              buffer_empty;
    logic [DW-1:0]     data_1;
    logic              data_1_en;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;
    logic [15:0]       word_count;

    int errors = 0;
    int checks = 0;

    // Reference model: granted flag, draining flag, last owner, next search start.
    // Also tracks words taken in the current grant and the total word count.
    bit          m_busy  = 0;
    bit          m_drain = 0;
    int          m_gid   = 0;
    int          m_rr    = 0;
    int          m_taken = 0;
    logic [15:0] m_cnt   = '0;
    bit          m_acc_last = 0;

    buffer_wr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk_1        (clk_1),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .buffer_full  (buffer_full),
        .buffer_empty (buffer_empty),
        .data_1       (data_1),
        .data_1_en    (data_1_en),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .word_count   (word_count)
    );

    always #5 clk_1 = ~clk_1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge
    task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic f, input logic e);
        bit acc;
        m_acc_last = 0;
        if (r) begin
            m_busy = 0; m_drain = 0; m_gid = 0; m_rr = 0; m_taken = 0; m_cnt = '0;
        end else if (m_drain) begin
            if (e) m_drain = 0;
        end else if (m_busy) begin
            acc = rq[m_gid] && !f;
            if (acc) begin
                m_taken++;
                m_cnt = m_cnt + 16'd1;
                m_acc_last = 1;
            end
            if (f) begin
                m_busy = 0; m_drain = 1;
            end else if (acc && m_taken == MB) begin
                m_busy = 0;
            end else if (!rq[m_gid]) begin
                m_busy = 0;
            end
        end else if (f) begin
            m_drain = 1;
        end else if (|rq) begin
            for (int k = 0; k < N; k++) begin
                if (rq[(m_rr + k) % N]) begin
                    m_gid   = (m_rr + k) % N;
                    m_rr    = (m_gid + 1) % N;
                    m_taken = 0;
                    m_busy  = 1;
                    break;
                end
            end
        end
    endtask

    // Drive inputs on the falling edge, check 1 time unit later, then take one clock edge
    task automatic step(input logic r, input logic [N-1:0] rq, input logic f, input logic e, input bit ck);
        logic [N-1:0] erdy;
        logic [IW-1:0] egid;
        rst = r; req = rq; buffer_full = f; buffer_empty = e;
        #1;
        if (ck) begin
            erdy = '0;
            if (m_busy && !f) erdy[m_gid] = 1'b1;
            egid = IW'(m_gid);
            chk("req_ready",   64'(req_ready),   64'(erdy));
            chk("data_1_en",   64'(data_1_en),   64'(m_busy && rq[m_gid] && !f));
            chk("grant_valid", 64'(grant_valid), 64'(m_busy));
            chk("grant_id",    64'(grant_id),    64'(egid));
            chk("word_count",  64'(word_count),  64'(m_cnt));
            chk("data_1",      64'(data_1),      64'(req_data[m_gid*DW +: DW]));
        end
        @(posedge clk_1);
        model_edge(r, rq, f, e);
        @(negedge clk_1);
    endtask

    initial begin
        logic [N-1:0] rq;
        logic         f, e, r;
        rst = 1'b1; req = '0; req_data = '0; buffer_full = 1'b0; buffer_empty = 1'b0;

        // T1: reset held with every requester active
        step(1, 4'hF, 0, 0, 0);
        step(1, 4'hF, 0, 0, 1);
        step(1, 4'hF, 0, 0, 1);

        // T2: single requester, data A000 upward, next word after each accept
        repeat (12) begin
            req_data[15:0] = 16'hA000 + m_cnt;
            step(0, 4'b0001, 0, 0, 1);
        end

        // T3: two requesters held, alternating grants
        step(1, '0, 0, 0, 1);
        req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        repeat (24) step(0, 4'b0101, 0, 0, 1);

        // T4: owner 1 drops req after two words
        step(1, '0, 0, 0, 1);
        for (int n = 0; n < 10 && !(m_busy && m_gid == 1 && m_taken == 2); n++)
            step(0, 4'b0010, 0, 0, 1);
        repeat (7) step(0, 4'b1100, 0, 0, 1);

        // T5: full after the third word, drain, then empty
        step(1, '0, 0, 0, 1);
        for (int n = 0; n < 10 && !(m_busy && m_taken == 3); n++)
            step(0, 4'b0001, 0, 0, 1);
        step(0, 4'b0001, 1, 0, 1);
        repeat (3) step(0, 4'b0001, 0, 0, 1);
        step(0, 4'b0001, 0, 1, 1);
        repeat (3) step(0, 4'b0001, 0, 0, 1);
        // illegal full+empty: full wins, leave drain next edge
        step(0, 4'b0001, 1, 1, 1);
        repeat (3) step(0, 4'b0001, 0, 1, 1);

        // T6: reset pulse mid-burst, then check rr restarts at 0
        for (int n = 0; n < 10 && !(m_busy && m_taken == 1); n++)
            step(0, 4'b0100, 0, 0, 1);
        step(1, 4'b0100, 0, 0, 1);
        repeat (4) step(0, 4'hF, 0, 0, 1);

        // Randomized traffic. Unused slices get X, and the owner's word changes only after it is accepted.
        rq = '0;
        repeat (800) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(4) == 0) rq[i] = ~rq[i];
            f = ($urandom_range(9) == 0);
            e = ($urandom_range(2) == 0);
            r = ($urandom_range(199) == 0);
            for (int i = 0; i < N; i++) begin
                if (m_busy && i == m_gid && !m_acc_last) begin
                    // hold the owner's pending word
                end else if (!rq[i] && i != m_gid && $urandom_range(1) == 1) begin
                    req_data[i*DW +: DW] = 'x;
                end else begin
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            step(r, rq, f, e, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
